inst_fetch_responder: RTL and testbench
=======================================

// Module: inst_fetch_responder
// PURPOSE
//  Memory-side responder for the instruction-fetch stage. Accepts a fetch request (pc) and reads
//  four consecutive bytes from the byte-wide RAM port. Returns the little-endian 32-bit instruction
//  on dt with a one-cycle ok pulse. Sits between the fetch stage (consumer of ok/dt, producer of pc)
//  and the single-port 8-bit RAM, which has a 1-cycle read latency.
// PARAMETERS
//  ADDR_W   17  RAM byte-address width; the low ADDR_W bits of pc are used.
//  XLEN     32  instruction/word width; fixed at 4 bytes.
// PORTS
//  clk        in   1       clock; all state changes on posedge.
//  rst        in   1       reset, asynchronous, active-low (0 = reset).
//  req        in   1       fetch request; pc is sampled only when the request is accepted.
//  pc         in   32      byte address of the instruction.
//  flush      in   1       abort any fetch in progress (branch redirect).
//  mem_busy   in   1       RAM port lent to another master this cycle; no new read may be issued.
//  mem_din    in   8       RAM read data; valid the cycle after mem_a/mem_rd_en were driven.
//  mem_a      out  ADDR_W  RAM byte address (registered).
//  mem_rd_en  out  1       read strobe for mem_a (registered).
//  ready      out  1       1 when state==IDLE; req is accepted only while ready=1.
//  ok         out  1       one-cycle pulse: dt holds a complete instruction.
//  dt         out  32      assembled instruction; holds its value until the next ok.
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, ok=0, dt=0, mem_a=0, mem_rd_en=0, byte count=0, in-flight flag=0.
//  States: IDLE -> ISSUE -> DRAIN -> IDLE.
//   IDLE:  req=1 & flush=0 -> latch pc, issue count k=0, go to ISSUE.
//   ISSUE: each cycle with mem_busy=0: mem_a<=pc[ADDR_W-1:0]+k, mem_rd_en<=1, k++.
//          After k=3 is issued, go to DRAIN. mem_busy=1: mem_rd_en<=0, k frozen, mem_a held.
//   DRAIN: wait for the last byte. When it is captured: ok<=1 next cycle, then go to IDLE.
//  Capture: an in-flight flag is mem_rd_en registered by one cycle. When the flag is set,
//   mem_din goes into byte lane j (j = capture count); byte0 -> dt[7:0], byte3 -> dt[31:24].
//   A read issued before mem_busy rose is still captured.
//  dt is updated only with ok. Partial bytes go into a shadow register, never visible on dt.
//  Latency with no stalls:
//   - req accepted in cycle 0; mem_a = pc..pc+3 in cycles 1..4.
//   - bytes arrive in cycles 2..5; ok=1 in cycle 6.
//   - each mem_busy cycle in ISSUE adds exactly 1 cycle.
//  ok cycle is an IDLE cycle, so a new req in the ok cycle is accepted. Throughput: 1 word per 6 cycles.
//  req while ready=0 is ignored, and pc changes are ignored after acceptance.
//  Address arithmetic is modulo 2^ADDR_W. pc+k wraps, e.g. 0x1FFFF -> 0x00000 for ADDR_W=17.
//  Misaligned pc is legal: bytes come from pc..pc+3 unchanged.
//  flush=1 (any state, takes priority over req): next edge state=IDLE, mem_rd_en=0, in-flight flag=0,
//   counts=0. ok is forced 0 in the following cycle and dt is left unchanged.
//   A flush in the cycle a word would complete suppresses that ok.
//  Reset mid-fetch: all state cleared immediately, and no ok is produced for the aborted fetch.
// STRUCTURE
//  Shared package (cpu_pkg):
//   - fetch-responder state enum (IDLE/ISSUE/DRAIN)
//   - XLEN=32
//   - BYTES_PER_INST=4
//  Single module. Byte-lane assembly is an indexed write into a 32-bit shadow register.
//  No sub-module is warranted.
// TESTING
//  1. RAM[0..3]=13,00,00,93; req, pc=0 -> mem_a 0,1,2,3 in cycles 1-4; ok only in cycle 6, dt=93000013.
//  2. Same request with mem_busy=1 in cycles 2-3 -> mem_a sequence 0,1,(held),(held),2,3.
//     ok in cycle 8, dt=93000013, no byte duplicated or lost.
//  3. pc=0x1FFFE, ADDR_W=17 -> mem_a 1FFFE,1FFFF,00000,00001; dt assembled from those bytes.
//  4. flush in cycle 3 of a fetch -> no ok and dt unchanged. A req in the next IDLE cycle for pc=8
//     returns the RAM[8..11] word 6 cycles later.
//  5. req held high continuously, pc=0,4,8 -> ok in cycles 6, 12, 18 with correct words.
//     req while ready=0 is ignored.
//  6. rst asserted in cycle 4 of a fetch -> all outputs 0 at once. After release, no stale ok,
//     and a new fetch completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: fetch-responder states and word geometry.
package cpu_pkg;

    localparam int XLEN           = 32;
    localparam int BYTES_PER_INST = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_responder.sv
// Fetches four bytes from an 8-bit, 1-cycle-latency RAM and returns one little-endian instruction.
// Latency: ok six cycles after req is accepted, plus one cycle per mem_busy cycle while issuing.
// Backpressure: ready low while a fetch is in flight; mem_busy stalls byte issue; flush aborts.
module inst_fetch_responder
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [31:0]       pc,
    input  logic              flush,
    input  logic              mem_busy,
    input  logic [7:0]        mem_din,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_rd_en,
    output logic              ready,
    output logic              ok,
    output logic [XLEN-1:0]   dt
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        issue_cnt_q, issue_cnt_d;
    logic [1:0]        cap_cnt_q, cap_cnt_d;
    logic              inflight_q, inflight_d;
    logic [XLEN-1:0]   shadow_q, shadow_d;
    logic [XLEN-1:0]   dt_q, dt_d;
    logic              ok_q, ok_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic              unused_pc;

    assign unused_pc = ^pc[31:ADDR_W];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        issue_cnt_d = issue_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        inflight_d  = mem_rd_en_q;
        shadow_d    = shadow_q;
        dt_d        = dt_q;
        ok_d        = 1'b0;
        mem_a_d     = mem_a_q;
        mem_rd_en_d = 1'b0;

        // A read strobed last cycle returns its byte now, whatever mem_busy is doing.
        if (inflight_q) begin
            shadow_d[{cap_cnt_q, 3'b000} +: 8] = mem_din;
            cap_cnt_d = cap_cnt_q + 2'd1;
            if (cap_cnt_q == 2'(BYTES_PER_INST - 1)) begin
                ok_d    = 1'b1;
                dt_d    = shadow_d;
                state_d = IDLE;
            end
        end

        case (state_q)
            IDLE: begin
                if (req) begin
                    pc_d        = pc[ADDR_W-1:0];
                    issue_cnt_d = 2'd0;
                    state_d     = ISSUE;
                    // Byte 0 goes out on the accept edge so mem_a shows pc in the next cycle.
                    if (!mem_busy) begin
                        mem_a_d     = pc[ADDR_W-1:0];
                        mem_rd_en_d = 1'b1;
                        issue_cnt_d = 2'd1;
                    end
                end
            end
            ISSUE: begin
                if (!mem_busy) begin
                    mem_a_d     = pc_q + ADDR_W'(issue_cnt_q);
                    mem_rd_en_d = 1'b1;
                    issue_cnt_d = issue_cnt_q + 2'd1;
                    if (issue_cnt_q == 2'(BYTES_PER_INST - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d     = IDLE;
            issue_cnt_d = 2'd0;
            cap_cnt_d   = 2'd0;
            inflight_d  = 1'b0;
            shadow_d    = shadow_q;
            dt_d        = dt_q;
            ok_d        = 1'b0;
            mem_a_d     = mem_a_q;
            mem_rd_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            issue_cnt_q <= 2'd0;
            cap_cnt_q   <= 2'd0;
            inflight_q  <= 1'b0;
            shadow_q    <= '0;
            dt_q        <= '0;
            ok_q        <= 1'b0;
            mem_a_q     <= '0;
            mem_rd_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            issue_cnt_q <= issue_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            inflight_q  <= inflight_d;
            shadow_q    <= shadow_d;
            dt_q        <= dt_d;
            ok_q        <= ok_d;
            mem_a_q     <= mem_a_d;
            mem_rd_en_q <= mem_rd_en_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign ok        = ok_q;
    assign dt        = dt_q;
    assign mem_a     = mem_a_q;
    assign mem_rd_en = mem_rd_en_q;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder: byte RAM model, cycle-level fetch model, per-cycle compare.
module tb_inst_fetch_responder;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic [31:0]   pc;
    logic          flush;
    logic          mem_busy;
    logic [7:0]    mem_din;
    logic [AW-1:0] mem_a;
    logic          mem_rd_en;
    logic          ready;
    logic          ok;
    logic [31:0]   dt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [7:0]  ram [0:(1<<AW)-1];
    logic [31:0] mseq [0:63];

    inst_fetch_responder #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .pc        (pc),
        .flush     (flush),
        .mem_busy  (mem_busy),
        .mem_din   (mem_din),
        .mem_a     (mem_a),
        .mem_rd_en (mem_rd_en),
        .ready     (ready),
        .ok        (ok),
        .dt        (dt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte-wide RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_din <= ram[mem_a];
    end

    function automatic logic [31:0] word_at(input logic [AW-1:0] a);
        return {ram[AW'(a + 3)], ram[AW'(a + 2)], ram[AW'(a + 1)], ram[a]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Fetch model: counts issued bytes (one per non-busy cycle, four in total); the word
    // appears two edges after the last byte is issued; flush drops the fetch.
    logic          m_active = 1'b0;
    logic [AW-1:0] m_pc     = '0;
    int            m_issued = 0;
    int            m_tail   = 0;
    logic          e_ok     = 1'b0;
    logic [31:0]   e_dt     = '0;
    logic [AW-1:0] e_a      = '0;
    logic          e_rd     = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 1'b0; m_issued = 0; m_tail = 0;
            e_ok = 1'b0; e_dt = '0; e_a = '0; e_rd = 1'b0;
        end else begin
            e_ok = 1'b0;
            e_rd = 1'b0;
            if (flush) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                if (req) begin
                    m_active = 1'b1;
                    m_pc     = pc[AW-1:0];
                    m_issued = 0;
                    if (!mem_busy) begin
                        e_rd = 1'b1; e_a = m_pc; m_issued = 1;
                    end
                end
            end else if (m_issued < 4) begin
                if (!mem_busy) begin
                    e_rd = 1'b1;
                    e_a  = AW'(m_pc + m_issued);
                    m_issued++;
                    if (m_issued == 4) m_tail = 2;
                end
            end else begin
                m_tail--;
                if (m_tail == 0) begin
                    e_ok = 1'b1; e_dt = word_at(m_pc); m_active = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_ok", ok, e_ok);
        chk("cmp_dt", dt, e_dt);
        chk("cmp_ready", ready, !m_active);
        chk("cmp_mem_rd_en", mem_rd_en, e_rd);
        chk("cmp_mem_a", mem_a, e_a);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request in the current cycle and waits (bounded) for ok.
    task automatic do_fetch(input logic [31:0] a, input logic [15:0] busy,
                            input int exp_n, input logic [31:0] exp_w, input string tag);
        int n;
        req = 1'b1; pc = a; mem_busy = busy[0];
        step();
        req = 1'b0; pc = 32'hFFFF_FFFF;
        n = 1;
        while (!ok && n < 40) begin
            mseq[n]  = mem_a;
            mem_busy = (n < 16) ? busy[n] : 1'b0;
            step();
            n++;
        end
        mem_busy = 1'b0;
        chk({tag, "_latency"}, n, exp_n);
        chk({tag, "_dt"}, dt, exp_w);
    endtask

    int t2_exp [6] = '{0, 1, 1, 1, 2, 3};
    int t3_exp [4] = '{32'h1FFFE, 32'h1FFFF, 32'h00000, 32'h00001};
    int oks;

    initial begin
        rst = 1'b0; req = 1'b0; pc = '0; flush = 1'b0; mem_busy = 1'b0; mem_din = '0;
        for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
        ram[0] = 8'h13; ram[1] = 8'h00; ram[2] = 8'h00; ram[3] = 8'h93;
        ram[4] = 8'h78; ram[5] = 8'h56; ram[6] = 8'h34; ram[7] = 8'h12;
        ram[8] = 8'hEF; ram[9] = 8'hBE; ram[10] = 8'hAD; ram[11] = 8'hDE;
        ram[17'h1FFFE] = 8'h11; ram[17'h1FFFF] = 8'h22;

        step(); step();
        chk("rst_ok", ok, 0);
        chk("rst_dt", dt, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_ready", ready, 1);
        rst = 1'b1;
        step();

        // 1: plain fetch
        do_fetch(32'h0, 16'h0000, 6, 32'h9300_0013, "t1");
        for (int i = 1; i <= 4; i++) chk("t1_mem_a", mseq[i], i - 1);

        // 2: mem_busy in cycles 2 and 3
        do_fetch(32'h0, 16'h000C, 8, 32'h9300_0013, "t2");
        for (int i = 1; i <= 6; i++) chk("t2_mem_a", mseq[i], t2_exp[i-1]);

        // 3: address wrap, upper pc bits ignored
        do_fetch(32'hABC1_FFFE, 16'h0000, 6, 32'h0013_2211, "t3");
        for (int i = 1; i <= 4; i++) chk("t3_mem_a", mseq[i], t3_exp[i-1]);

        // 4: flush in cycle 3, then a new fetch in the next idle cycle
        req = 1'b1; pc = 32'h0;
        step(); req = 1'b0;
        step();
        step(); flush = 1'b1;
        step(); flush = 1'b0;
        chk("t4_ok_after_flush", ok, 0);
        chk("t4_dt_kept", dt, 32'h0013_2211);
        chk("t4_ready", ready, 1);
        do_fetch(32'h8, 16'h0000, 6, 32'hDEAD_BEEF, "t4b");

        // flush in the cycle the last byte is captured suppresses ok
        req = 1'b1; pc = 32'h4;
        step(); req = 1'b0;
        for (int i = 2; i <= 5; i++) step();
        flush = 1'b1;
        step(); flush = 1'b0;
        chk("flush_last_ok", ok, 0);
        chk("flush_last_dt", dt, 32'hDEAD_BEEF);
        step();

        // 5: req held high; pc noise while busy must be ignored
        req = 1'b1; pc = 32'h0; oks = 0;
        for (int c = 1; c <= 18; c++) begin
            step();
            if (ok) oks++;
            if (c == 3) chk("t5_ready_busy", ready, 0);
            if (c == 6) begin
                chk("t5_ok6", ok, 1); chk("t5_dt6", dt, 32'h9300_0013); pc = 32'h4;
            end else if (c == 12) begin
                chk("t5_ok12", ok, 1); chk("t5_dt12", dt, 32'h1234_5678); pc = 32'h8;
            end else if (c == 18) begin
                chk("t5_ok18", ok, 1); chk("t5_dt18", dt, 32'hDEAD_BEEF); req = 1'b0;
            end else begin
                pc = 32'h100 + c;
            end
        end
        chk("t5_ok_count", oks, 3);
        step();

        // 6: reset in cycle 4 of a fetch
        req = 1'b1; pc = 32'h4;
        step(); req = 1'b0;
        step(); step(); step();
        rst = 1'b0;
        #1;
        chk("t6_ok", ok, 0);
        chk("t6_dt", dt, 0);
        chk("t6_mem_a", mem_a, 0);
        chk("t6_mem_rd_en", mem_rd_en, 0);
        chk("t6_ready", ready, 1);
        step();
        rst = 1'b1;
        oks = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ok) oks++;
        end
        chk("t6_no_stale_ok", oks, 0);
        do_fetch(32'h8, 16'h0000, 6, 32'hDEAD_BEEF, "t6b");
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
